// File: rtl/bcd_serial_add_ctrl.sv
// rtl/bcd_serial_add_ctrl.sv - digit-serial BCD adder sequencer sharing one single-digit adder stage
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [4*DIGITS-1:0]   a_i,
    input  logic [4*DIGITS-1:0]   b_i,
    input  logic                  cin_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [4*DIGITS-1:0]   sum_o,
    output logic                  cout_o
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [4*DIGITS-1:0] op_a_q, op_a_d;
    logic [4*DIGITS-1:0] op_b_q, op_b_d;
    logic [4*DIGITS-1:0] work_q, work_d;
    logic [4*DIGITS-1:0] sum_q, sum_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                carry_q, carry_d;
    logic                cout_q, cout_d;
    logic                err_q, err_d;

    logic                any_bad;
    logic [3:0]          a_dig, b_dig, dig;
    logic [4:0]          dsum;
    logic                dcarry;

    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a_i[4*i +: 4] > 4'd9 || b_i[4*i +: 4] > 4'd9) begin
                any_bad = 1'b1;
            end
        end
    end

    // The single shared digit stage: selected digit pair plus rippled carry, decimal-corrected
    always_comb begin
        a_dig  = 4'(op_a_q >> {idx_q, 2'b00});
        b_dig  = 4'(op_b_q >> {idx_q, 2'b00});
        dsum   = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry_q};
        dcarry = (dsum > 5'd9);
        dig    = dcarry ? 4'(dsum - 5'd10) : dsum[3:0];
    end

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        work_d  = work_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        err_d   = err_q;
        case (state_q)
            S_ADD: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        work_d[4*i +: 4] = dig;
                    end
                end
                carry_d = dcarry;
                if (idx_q == IDX_LAST) begin
                    sum_d   = work_d;
                    cout_d  = dcarry;
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    op_a_d  = a_i;
                    op_b_d  = b_i;
                    carry_d = cin_i;
                    idx_d   = '0;
                    work_d  = '0;
                    err_d   = any_bad;
                    if (any_bad) begin
                        sum_d   = '0;
                        cout_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ADD;
                    end
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    assign busy_o = (state_q == S_ADD);
    assign done_o = (state_q == S_DONE);
    assign err_o  = err_q;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb/tb_bcd_serial_add_ctrl.sv - scoreboard bench for bcd_serial_add_ctrl against a decimal reference model
module tb_bcd_serial_add_ctrl;

    localparam int D = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [4*D-1:0] a, b;
    logic           cin;
    logic           busy, done, err, cout;
    logic [4*D-1:0] sum;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_cnt = 0;
    int stall = 0;

    typedef struct {
        logic [4*D-1:0] sum;
        logic           cout;
        logic           err;
        int             cyc;
        int             busy;
    } exp_t;

    exp_t q[$];

    bcd_serial_add_ctrl #(.DIGITS(D)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a), .b_i(b), .cin_i(cin),
        .busy_o(busy), .done_o(done), .err_o(err), .sum_o(sum), .cout_o(cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic exp_t model(input logic [4*D-1:0] av, input logic [4*D-1:0] bv,
                                   input logic ci, input int c);
        exp_t e;
        int   ai, bi, t, p;
        logic [3:0] na, nb;
        logic bad;
        bad = 1'b0;
        ai = 0; bi = 0; p = 1;
        for (int i = 0; i < D; i++) begin
            na = av[4*i +: 4];
            nb = bv[4*i +: 4];
            if (na > 9 || nb > 9) bad = 1'b1;
            ai += int'(na) * p;
            bi += int'(nb) * p;
            p *= 10;
        end
        e.sum = '0;
        if (bad) begin
            e.cout = 1'b0; e.err = 1'b1; e.cyc = c + 1; e.busy = 0;
        end else begin
            t = ai + bi + int'(ci);
            e.cout = (t >= p);
            t = t % p;
            for (int i = 0; i < D; i++) begin
                e.sum[4*i +: 4] = 4'(t % 10);
                t = t / 10;
            end
            e.err = 1'b0; e.cyc = c + 1 + D; e.busy = D;
        end
        return e;
    endfunction

    // Monitor: every Done pulse is matched against the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (busy) busy_cnt++;
            if (done) begin
                stall = 0;
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sum", 32'(sum), 32'(e.sum));
                    chk("cout", 32'(cout), 32'(e.cout));
                    chk("err", 32'(err), 32'(e.err));
                    chk("done_latency", 32'(cyc), 32'(e.cyc));
                    chk("busy_cycles", 32'(busy_cnt), 32'(e.busy));
                end
                busy_cnt = 0;
            end else if (q.size() > 0) begin
                stall++;
                if (stall > 50) begin
                    chk("done_timeout", 32'(stall), 32'd0);
                    void'(q.pop_front());
                    stall = 0;
                end
            end else begin
                stall = 0;
            end
        end
    end

    task automatic do_op(input logic [4*D-1:0] av, input logic [4*D-1:0] bv,
                         input logic ci, input int gap);
        exp_t e;
        a = av; b = bv; cin = ci; start = 1'b1;
        e = model(av, bv, ci, cyc);
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        if (!e.err) repeat (D) @(negedge clk);
        repeat (gap) @(negedge clk);
    endtask

    function automatic logic [4*D-1:0] rand_operand(input bit allow_bad);
        logic [4*D-1:0] v;
        for (int i = 0; i < D; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        if (allow_bad && $urandom_range(0, 19) == 0)
            v[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
        return v;
    endfunction

    initial begin
        exp_t e;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op(16'h1234, 16'h5678, 1'b0, 2);
        do_op(16'h9999, 16'h0001, 1'b0, 1);
        do_op(16'h9999, 16'h9999, 1'b1, 2);
        do_op(16'h00A0, 16'h0001, 1'b0, 2);
        chk("err_held_idle", 32'(err), 32'd1);
        chk("sum_held_idle", 32'(sum), 32'd0);

        // Start during ADD with different operands must be ignored
        a = 16'h0102; b = 16'h0304; cin = 1'b1; start = 1'b1;
        e = model(a, b, cin, cyc);
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'h4444; b = 16'h5555; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (D - 2) @(negedge clk);
        do_op(16'h0005, 16'h0005, 1'b0, 2);
        chk("sum_held_after_done", 32'(sum), 32'h0010);
        chk("err_cleared", 32'(err), 32'd0);

        // Reset in the second ADD cycle abandons the op
        a = 16'h4321; b = 16'h1111; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);
        chk("midreset_err", 32'(err), 32'd0);
        chk("midreset_sum", 32'(sum), 32'd0);
        chk("midreset_cout", 32'(cout), 32'd0);
        q.delete();
        busy_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_op(16'h0001, 16'h0002, 1'b0, 2);

        for (int n = 0; n < 500; n++) begin
            do_op(rand_operand(1'b1), rand_operand(1'b1), 1'($urandom), int'($urandom_range(0, 2)));
        end

        for (int w = 0; w < 100 && q.size() > 0; w++) @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
